// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a requester and alu_sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command channel (requester -> sequencer)
//   rsp_valid/rsp_ready/rsp_data/rsp_flag/rsp_err : response channel (sequencer -> requester)
interface alu_sequencer_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_flag;
  logic              rsp_err;

  // Requester side
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flag, rsp_err
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flag, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving one shared 16-bit combinational ALU:
// 32-bit add/sub in two chained passes, 16x16 unsigned multiply in 16 shift-add passes.
//   clk, reset : clock and synchronous active-high reset
//   bus        : command/response handshake (slave side)
//   alu_a/alu_b/alu_cin/alu_op : ALU operand/opcode outputs (registered)
//   alu_c/alu_cout             : ALU result inputs, sampled at the end of each pass
module alu_sequencer (
  input  logic                 clk,
  input  logic                 reset,
  alu_sequencer_if.slave       bus,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic                 alu_cin,
  output logic [3:0]           alu_op,
  input  logic [15:0]          alu_c,
  input  logic                 alu_cout
);
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam logic [3:0]  OP_ADD  = 4'b0000;
  localparam logic [3:0]  OP_PASS = 4'b0010;

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   a_hi_q, a_hi_d;
  logic [HALF_W-1:0]   b_hi_q, b_hi_d;
  logic [WORD_W-1:0]   p_q, p_d;
  logic [HALF_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_flag_q, rsp_flag_d;
  logic                rsp_err_q, rsp_err_d;
  logic [HALF_W-1:0]   alu_a_q, alu_a_d;
  logic [HALF_W-1:0]   alu_b_q, alu_b_d;
  logic                alu_cin_q, alu_cin_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [WORD_W-1:0]   p_next;

  // Next-state, datapath and ALU-drive logic; ALU drive values are set one
  // cycle ahead so the ALU pins come straight from flops.
  always_comb begin
    state_d     = state_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    p_d         = p_q;
    m_d         = m_q;
    count_d     = count_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_err_d   = rsp_err_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_op_d    = alu_op_q;
    // Shift-add step: carry and sum become the new upper half, multiplier shifts out
    p_next      = {alu_cout, alu_c, p_q[HALF_W-1:1]};

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          rsp_err_d   = 1'b0;
          a_hi_d      = bus.cmd_a[WORD_W-1:HALF_W];
          b_hi_d      = bus.cmd_b[WORD_W-1:HALF_W];
          alu_cin_d   = 1'b0;
          unique case (bus.cmd_op)
            2'b00, 2'b01: begin
              state_d  = S_LO;
              alu_a_d  = bus.cmd_a[HALF_W-1:0];
              alu_b_d  = bus.cmd_b[HALF_W-1:0];
              alu_op_d = {3'b000, bus.cmd_op[0]};
            end
            2'b10: begin
              state_d  = S_MUL;
              p_d      = {16'h0000, bus.cmd_a[HALF_W-1:0]};
              m_d      = bus.cmd_b[HALF_W-1:0];
              count_d  = '0;
              alu_a_d  = 16'h0000;
              alu_b_d  = bus.cmd_a[0] ? bus.cmd_b[HALF_W-1:0] : 16'h0000;
              alu_op_d = OP_ADD;
            end
            default: begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_flag_d  = 1'b0;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end
      S_LO: begin
        state_d                  = S_HI;
        rsp_data_d[HALF_W-1:0]   = alu_c;
        alu_a_d                  = a_hi_q;
        alu_b_d                  = b_hi_q;
        alu_cin_d                = alu_cout;
      end
      S_HI: begin
        state_d                       = S_RESP;
        rsp_data_d[WORD_W-1:HALF_W]   = alu_c;
        rsp_flag_d                    = alu_cout;
        rsp_valid_d                   = 1'b1;
        alu_a_d                       = '0;
        alu_b_d                       = '0;
        alu_cin_d                     = 1'b0;
        alu_op_d                      = OP_PASS;
      end
      S_MUL: begin
        p_d     = p_next;
        count_d = CNT_W'(count_q + CNT_W'(1));
        if (count_q == CNT_W'(15)) begin
          state_d     = S_RESP;
          rsp_data_d  = p_next;
          rsp_flag_d  = 1'b0;
          rsp_valid_d = 1'b1;
          alu_a_d     = '0;
          alu_b_d     = '0;
          alu_op_d    = OP_PASS;
        end else begin
          alu_a_d = p_next[WORD_W-1:HALF_W];
          alu_b_d = p_next[0] ? m_q : 16'h0000;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      p_q         <= '0;
      m_q         <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_op_q    <= OP_PASS;
    end else begin
      state_q     <= state_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      p_q         <= p_d;
      m_q         <= m_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_err_q   <= rsp_err_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_cin       = alu_cin_q;
  assign alu_op        = alu_op_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural 16-bit ALU, directed cases
// plus randomized commands checked against a plain-arithmetic reference model.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_a, alu_b, alu_c;
  logic        alu_cin, alu_cout;
  logic [3:0]  alu_op;

  int checks   = 0;
  int failures = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_op   (alu_op),
    .alu_c    (alu_c),
    .alu_cout (alu_cout)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU
  always_comb begin
    alu_c    = 16'h0000;
    alu_cout = 1'b0;
    case (alu_op)
      4'd0: {alu_cout, alu_c} = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);
      4'd1: begin
        alu_c    = alu_a - alu_b - 16'(alu_cin);
        alu_cout = 17'(alu_a) < (17'(alu_b) + 17'(alu_cin));
      end
      4'd2: alu_c = alu_a;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, flag, error, low-half carry/borrow and response latency
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic f, output logic e,
                       output logic lc, output int lat);
    logic [32:0] s;
    logic [16:0] sl;
    d = 32'h0; f = 1'b0; e = 1'b0; lc = 1'b0; lat = 0;
    case (op)
      2'd0: begin
        s = 33'(a) + 33'(b); d = s[31:0]; f = s[32];
        sl = 17'(a[15:0]) + 17'(b[15:0]); lc = sl[16]; lat = 2;
      end
      2'd1: begin
        d = a - b; f = (a < b); lc = (a[15:0] < b[15:0]); lat = 2;
      end
      2'd2: begin
        d = 32'(a[15:0]) * 32'(b[15:0]); lat = 16;
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] ed;
    logic ef, ee, elc, lo_cout, hi_cin;
    int elat, lat, w;
    model(op, a, b, ed, ef, ee, elc, elat);
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("cmd_ready_pre", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_a = $urandom; bus.cmd_b = $urandom;
    check("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
    lat = 0; lo_cout = 1'bx; hi_cin = 1'bx;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      if (lat == 0) lo_cout = alu_cout;
      if (lat == 1) hi_cin = alu_cin;
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    check("rsp_data", 64'(bus.rsp_data), 64'(ed));
    check("rsp_flag", 64'(bus.rsp_flag), 64'(ef));
    check("rsp_err", 64'(bus.rsp_err), 64'(ee));
    if (op < 2'd2) begin
      check("lo_carry", 64'(lo_cout), 64'(elc));
      check("hi_cin", 64'(hi_cin), 64'(elc));
    end
    // Hold off the consumer; a stray command must not be taken
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0;
      @(posedge clk); #1;
      check("bp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_flag, bus.rsp_err, bus.rsp_data},
            {1'b1, 1'b0, ef, ee, ed});
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("post_rsp", {bus.rsp_valid, bus.cmd_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state",
          {bus.cmd_ready, bus.rsp_valid, bus.rsp_flag, bus.rsp_err, bus.rsp_data, alu_op},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0010});

    issue(2'd0, 32'h0000FFFF, 32'h00000001, 0);
    issue(2'd0, 32'hFFFFFFFF, 32'h00000001, 0);
    issue(2'd1, 32'h00010000, 32'h00000001, 0);
    issue(2'd1, 32'h00000000, 32'h00000001, 0);
    issue(2'd2, 32'h0000FFFF, 32'h0000FFFF, 5);
    issue(2'd2, 32'h00001234, 32'h00000000, 0);
    issue(2'd2, 32'h000000FF, 32'h00000101, 0);
    issue(2'd3, 32'hDEADBEEF, 32'h12345678, 2);
    issue(2'd0, 32'h00000002, 32'h00000003, 0);

    // Reset while the multiply is at count 7
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_a = 32'h1234; bus.cmd_b = 32'h5678;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset", {bus.rsp_valid, bus.cmd_ready}, {1'b0, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    check("no_rsp_after_reset", 64'(seen), 64'(0));
    issue(2'd2, 32'h00000003, 32'h00000005, 0);

    for (int n = 0; n < 24; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      issue(op, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
